nco_state_ram: RTL and testbench
================================

# nco_state_ram

Parametrised dual-read, single-write state memory for the oscillator NCO engine, holding one D_WIDTH-bit state word (phase accumulator, reset flag, pitch value) per voice/oscillator slot. It sits between the NCO update pipeline and the oscillator core. It adds the following over the previous NCO RAM:
- single-clock operation with asynchronous reset;
- a self-clearing initialisation sweep after reset;
- per-port read-enable with valid strobes;
- write-to-read forwarding;
- out-of-range address protection.

## Interface
Parameters:
- VOICES, 8, number of voices
- V_OSC, 8, oscillators per voice
- V_WIDTH, 3, voice index bits
- O_WIDTH, 3, oscillator index bits; ADDR_W = V_WIDTH+O_WIDTH, DEPTH = VOICES*V_OSC, requires DEPTH <= 2^ADDR_W
- D_WIDTH, 51, state word width
- INIT_VAL, 0, D_WIDTH-bit value written to every slot during init and returned for out-of-range reads

Ports:
- sCLK_XVXENVS  in  1  sole clock, rising edge
- reset_reg_N  in  1  asynchronous active-low reset
- we  in  1  write request
- write_address  in  ADDR_W  write slot
- d  in  D_WIDTH  write data
- rea  in  1  port A read request
- reada_address  in  ADDR_W  port A slot
- reb  in  1  port B read request
- readb_address  in  ADDR_W  port B slot
- qa  out  D_WIDTH  port A data
- qb  out  D_WIDTH  port B data
- qa_valid  out  1  one-cycle strobe, qa updated this cycle
- qb_valid  out  1  one-cycle strobe, qb updated this cycle
- init_busy  out  1  initialisation sweep in progress; requests ignored

## Operation
- FSM states are INIT and RUN. Reset forces INIT and init_cnt=0.
- INIT:
  - each edge writes mem[init_cnt] = INIT_VAL and increments init_cnt;
  - at init_cnt == DEPTH-1, the write occurs, then the FSM goes to RUN and init_busy goes to 0.
  - we/rea/reb are not sampled; stage-1 valid registers are held at 0.
- Stage 1 (RUN, every edge): register we, write_address and d into wv/wa/wd. Register rea/reada_address into rav/ra, and reb/readb_address into rbv/rb.
- Stage 2:
  - If wv and wa < DEPTH, mem[wa] <= wd.
  - If rav, qa <= (wv && wa==ra && ra<DEPTH) ? wd : (ra<DEPTH ? mem[ra] : INIT_VAL). Port B is identical using rbv/rb.
  - qa_valid <= rav and qb_valid <= rbv. When not valid, qa and qb hold their previous value.
- The collision rule is write-first: a read and a write to the same slot in the same stage-2 cycle returns the new data.
- A write with wa >= DEPTH is dropped with no side effect.
- Ports A and B are fully independent and may address the same slot.
- Reset asserted mid-operation: all pipeline registers and outputs clear immediately, pending stage-1 writes are lost, and the sweep restarts from slot 0.

## Timing
- Reset values: qa=0, qb=0, qa_valid=0, qb_valid=0, init_busy=1, FSM=INIT, init_cnt=0, and all stage-1 valid registers 0.
- Init duration is exactly DEPTH edges after reset release. init_busy falls at the DEPTH-th rising edge. The first request accepted is one sampled at edge DEPTH+1.
- Read latency: request sampled at edge N gives qa/qb and valid at edge N+1, visible in cycle N+1..N+2. Valid is high for exactly one cycle per request.
- Write latency: request sampled at edge N commits at edge N+1. A read sampled at edge N (same cycle as the write) gets the new data through forwarding. A read sampled at edge N+1 or later gets it from memory.
- Throughput is one write plus two reads per clock, sustained, with no stalls.

## Test plan
- Init sweep (DEPTH=64, INIT_VAL=51'h5A5): release reset. Required response:
  - init_busy falls at edge 64;
  - we=1 asserted at edges 1–64 changes nothing;
  - reading all 64 slots returns 51'h5A5 with one qa_valid pulse each.
- Basic latency: write d=51'h123456789 to slot 10. Next cycle, read slot 10 on port A. Required response: qa=51'h123456789 and qa_valid=1 exactly one cycle after the read is sampled.
- Collision forwarding: in the same cycle, write 51'h7FF to slot 5, read slot 5 on port A, and read slot 6 on port B. Required response: qa=51'h7FF; qb=the prior slot-6 contents.
- Dual-port streaming: write slots 0..63 with the value addr*3. Then read 0..63 ascending on A and 63..0 descending on B, back-to-back. Required response: every cycle both valids are 1 and the data matches.
- Out-of-range (VOICES=6, V_OSC=8, DEPTH=48): write 51'h1 to address 50, then read 50 and read 50 mod 48=2. Required response: INIT_VAL both times; slot 2 is unchanged.
- Mid-operation reset: assert reset_reg_N low for half a cycle while a write and a read are in flight. Required response:
  - outputs are 0 immediately and init_busy=1;
  - the in-flight write is absent after re-init;
  - init_busy falls DEPTH edges after release.

Source files
------------

// File: rtl/nco_state_ram.sv
// nco_state_ram: per-slot NCO state store, one write and two reads per clock.
// Clears itself after reset and forwards same-cycle writes to the read ports.
module nco_state_ram #(
   parameter int VOICES = 8,
   parameter int V_OSC = 8,
   parameter int V_WIDTH = 3,
   parameter int O_WIDTH = 3,
   parameter int D_WIDTH = 51,
   parameter logic [D_WIDTH-1:0] INIT_VAL = '0,
   localparam int ADDR_W = V_WIDTH + O_WIDTH
) (
   input  logic               sCLK_XVXENVS,
   input  logic               reset_reg_N,
   input  logic               we,
   input  logic [ADDR_W-1:0]  write_address,
   input  logic [D_WIDTH-1:0] d,
   input  logic               rea,
   input  logic [ADDR_W-1:0]  reada_address,
   input  logic               reb,
   input  logic [ADDR_W-1:0]  readb_address,
   output logic [D_WIDTH-1:0] qa,
   output logic [D_WIDTH-1:0] qb,
   output logic               qa_valid,
   output logic               qb_valid,
   output logic               init_busy
);

   localparam int DEPTH = VOICES * V_OSC;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [ADDR_W-1:0]  init_cnt;
   logic               init_last;

   logic [D_WIDTH-1:0] mem [DEPTH];

   logic               wv;
   logic               rav;
   logic               rbv;
   logic [ADDR_W-1:0]  wa;
   logic [ADDR_W-1:0]  ra;
   logic [ADDR_W-1:0]  rb;
   logic [D_WIDTH-1:0] wd;

   logic               wa_ok;
   logic               ra_ok;
   logic               rb_ok;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_wa;
   logic [D_WIDTH-1:0] mem_wd;
   logic [D_WIDTH-1:0] qa_nxt;
   logic [D_WIDTH-1:0] qb_nxt;

   assign init_last = (init_cnt == LAST);
   assign wa_ok = ({1'b0, wa} < DEPTH_X);
   assign ra_ok = ({1'b0, ra} < DEPTH_X);
   assign rb_ok = ({1'b0, rb} < DEPTH_X);

   // FSM state register
   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Sweep until the last slot is written, then serve requests
   always_comb begin
      state_d = state_q;
      init_busy = 1'b0;
      unique case (state_q)
         INIT: begin
            init_busy = 1'b1;
            if (init_last) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Sweep pointer, walks every slot once after reset
   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         init_cnt <= '0;
      end else if (state_q == INIT) begin
         if (init_last) begin
            init_cnt <= '0;
         end else begin
            init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   // Stage 1: capture requests, suppressed while sweeping
   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         wv  <= 1'b0;
         rav <= 1'b0;
         rbv <= 1'b0;
         wa  <= '0;
         ra  <= '0;
         rb  <= '0;
         wd  <= '0;
      end else if (state_q == RUN) begin
         wv  <= we;
         rav <= rea;
         rbv <= reb;
         wa  <= write_address;
         ra  <= reada_address;
         rb  <= readb_address;
         wd  <= d;
      end else begin
         wv  <= 1'b0;
         rav <= 1'b0;
         rbv <= 1'b0;
      end
   end

   // Single write port shared by the sweep and stage 2
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wa;
      mem_wd = wd;
      if (init_busy) begin
         mem_we = 1'b1;
         mem_wa = init_cnt;
         mem_wd = INIT_VAL;
      end else if (wv && wa_ok) begin
         mem_we = 1'b1;
      end
   end

   // Storage array, contents defined by the sweep rather than reset
   always_ff @(posedge sCLK_XVXENVS) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // Read data with write-first forwarding and range guard
   always_comb begin
      qa_nxt = INIT_VAL;
      qb_nxt = INIT_VAL;
      if (ra_ok) begin
         qa_nxt = (wv && wa == ra) ? wd : mem[ra];
      end
      if (rb_ok) begin
         qb_nxt = (wv && wa == rb) ? wd : mem[rb];
      end
   end

   // Stage 2 outputs: data held between valid strobes
   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         qa       <= '0;
         qb       <= '0;
         qa_valid <= 1'b0;
         qb_valid <= 1'b0;
      end else begin
         qa_valid <= rav;
         qb_valid <= rbv;
         if (rav) begin
            qa <= qa_nxt;
         end
         if (rbv) begin
            qb <= qb_nxt;
         end
      end
   end

endmodule

// File: tb/tb_nco_state_ram.sv
// tb_nco_state_ram: two instances (64 and 48 slots) driven in lockstep,
// checked against an array model of the slot contents.
module tb_nco_state_ram;

   localparam logic [50:0] IV = 51'h5A5;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [5:0]  wadr;
   logic [50:0] d;
   logic        rea;
   logic [5:0]  radr;
   logic        reb;
   logic [5:0]  rbdr;
   logic [50:0] qa [2];
   logic [50:0] qb [2];
   logic        qav [2];
   logic        qbv [2];
   logic        busy [2];

   int ncmp = 0;
   int nerr = 0;
   int k = 0;
   int dep [2] = '{64, 48};

   logic [50:0] mdl [2][64];
   logic        pva [2];
   logic        pvb [2];
   logic [50:0] pqa [2];
   logic [50:0] pqb [2];
   logic [50:0] eqa [2];
   logic [50:0] eqb [2];

   nco_state_ram #(.INIT_VAL(IV)) u64 (
      .sCLK_XVXENVS(clk), .reset_reg_N(rst_n),
      .we(we), .write_address(wadr), .d(d),
      .rea(rea), .reada_address(radr),
      .reb(reb), .readb_address(rbdr),
      .qa(qa[0]), .qb(qb[0]),
      .qa_valid(qav[0]), .qb_valid(qbv[0]),
      .init_busy(busy[0])
   );

   nco_state_ram #(.VOICES(6), .INIT_VAL(IV)) u48 (
      .sCLK_XVXENVS(clk), .reset_reg_N(rst_n),
      .we(we), .write_address(wadr), .d(d),
      .rea(rea), .reada_address(radr),
      .reb(reb), .readb_address(rbdr),
      .qa(qa[1]), .qb(qb[1]),
      .qa_valid(qav[1]), .qb_valid(qbv[1]),
      .init_busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [50:0] obs,
                      input logic [50:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 64; a++) mdl[i][a] = IV;
         pva[i] = 1'b0;
         pvb[i] = 1'b0;
         pqa[i] = '0;
         pqb[i] = '0;
         eqa[i] = '0;
         eqb[i] = '0;
      end
   endtask

   // Called at a negedge; returns at the next negedge after checking.
   task automatic step(input logic w, input logic [5:0] wa_i,
                       input logic [50:0] wd_i,
                       input logic ae, input logic [5:0] aa,
                       input logic be, input logic [5:0] ba);
      logic cva [2];
      logic cvb [2];
      logic acc;
      we = w; wadr = wa_i; d = wd_i;
      rea = ae; radr = aa; reb = be; rbdr = ba;
      @(posedge clk);
      k++;
      for (int i = 0; i < 2; i++) begin
         cva[i] = pva[i];
         cvb[i] = pvb[i];
         if (cva[i]) eqa[i] = pqa[i];
         if (cvb[i]) eqb[i] = pqb[i];
         acc = (k >= dep[i] + 1);
         if (acc && w && int'(wa_i) < dep[i]) mdl[i][wa_i] = wd_i;
         pva[i] = acc && ae;
         pvb[i] = acc && be;
         pqa[i] = (int'(aa) < dep[i]) ? mdl[i][aa] : IV;
         pqb[i] = (int'(ba) < dep[i]) ? mdl[i][ba] : IV;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("busy%0d k=%0d", i, k), 51'(busy[i]),
             51'(k < dep[i]));
         chk($sformatf("qa_valid%0d k=%0d", i, k), 51'(qav[i]),
             51'(cva[i]));
         chk($sformatf("qb_valid%0d k=%0d", i, k), 51'(qbv[i]),
             51'(cvb[i]));
         chk($sformatf("qa%0d k=%0d", i, k), qa[i], eqa[i]);
         chk($sformatf("qb%0d k=%0d", i, k), qb[i], eqb[i]);
      end
   endtask

   task automatic idle();
      step(1'b0, 6'd0, 51'd0, 1'b0, 6'd0, 1'b0, 6'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, " qa"}, qa[i], 51'd0);
         chk({tag, " qb"}, qb[i], 51'd0);
         chk({tag, " qa_valid"}, 51'(qav[i]), 51'd0);
         chk({tag, " qb_valid"}, 51'(qbv[i]), 51'd0);
         chk({tag, " busy"}, 51'(busy[i]), 51'd1);
      end
   endtask

   initial begin
      logic [50:0] r;
      we = 0; wadr = 0; d = 0;
      rea = 0; radr = 0; reb = 0; rbdr = 0;
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      rst_n = 1'b1;
      k = 0;

      // sweep: writes and reads during init must be ignored
      for (int i = 0; i < 64; i++) begin
         r = {19'($urandom), 32'($urandom)};
         step(1'b1, 6'(i), r, 1'b1, 6'($urandom_range(0, 63)),
              1'b1, 6'($urandom_range(0, 63)));
      end
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 6'd0, 51'd0, 1'b1, 6'(i), 1'b0, 6'd0);
      end
      idle();

      // basic latency
      step(1'b1, 6'd10, 51'h123456789, 1'b0, 6'd0, 1'b0, 6'd0);
      step(1'b0, 6'd0, 51'd0, 1'b1, 6'd10, 1'b0, 6'd0);
      idle();

      // collision forwarding
      step(1'b1, 6'd5, 51'h7FF, 1'b1, 6'd5, 1'b1, 6'd6);
      idle();

      // dual-port streaming
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 6'(i), 51'(i * 3), 1'b0, 6'd0, 1'b0, 6'd0);
      end
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 6'd0, 51'd0, 1'b1, 6'(i), 1'b1, 6'(63 - i));
      end
      idle();

      // out-of-range on the 48-slot instance
      step(1'b1, 6'd50, 51'h1, 1'b0, 6'd0, 1'b0, 6'd0);
      step(1'b0, 6'd0, 51'd0, 1'b1, 6'd50, 1'b1, 6'd2);
      idle();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         r = {19'($urandom), 32'($urandom)};
         step(1'($urandom), 6'($urandom_range(0, 63)), r,
              1'($urandom), 6'($urandom_range(0, 63)),
              1'($urandom), 6'($urandom_range(0, 63)));
      end

      // mid-operation reset with a write and reads in flight
      we = 1'b1; wadr = 6'd20; d = 51'h3_DEAD_BEEF;
      rea = 1'b1; radr = 6'd20; reb = 1'b1; rbdr = 6'd21;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      model_clear();
      for (int i = 0; i < 66; i++) idle();
      step(1'b0, 6'd0, 51'd0, 1'b1, 6'd20, 1'b1, 6'd21);
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
